// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-segment scan controller with shadow/active digit banks
//
// Purpose: drives DIGITS common-cathode-style digits one at a time, each for DWELL
// cycles, decoding a hex nibble per digit. Writes land in a shadow bank; the whole
// shadow bank is copied to the displayed (active) bank on the frame-commit cycle,
// which is the cycle that wraps the digit index back to 0.
//
// Optional feature macro: SEG7_BLANK_EN inserts BLANK_CYC dead cycles between digits.
//
// Ports:
//   clk         clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   wr_valid    write request
//   wr_ready    write accepted when wr_valid && wr_ready (low on frame-commit cycle)
//   wr_idx      target digit; indices >= DIGITS are accepted and dropped
//   wr_data     hex nibble for target digit
//   wr_dp       decimal point for target digit
//   segment     active-high segments, bit 0 = a .. bit 6 = g
//   dp          active-high decimal point
//   digit_en    one-hot digit enable, or all zero
//   frame_tick  one-cycle pulse on the frame-commit cycle
module seg7_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int DWELL     = 15000,
    parameter int CBITS     = 14,
    parameter int BLANK_CYC = 16,
    localparam int IW       = $clog2(DIGITS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [IW-1:0]     wr_idx,
    input  logic [3:0]        wr_data,
    input  logic              wr_dp,
    output logic [6:0]        segment,
    output logic              dp,
    output logic [DIGITS-1:0] digit_en,
    output logic              frame_tick
);

`ifdef SEG7_BLANK_EN
    typedef enum logic {S_SCAN = 1'b0, S_BLANK = 1'b1} state_t;
`else
    typedef enum logic [0:0] {S_SCAN = 1'b0} state_t;
`endif

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CBITS-1:0]  cnt_q, cnt_d;
    logic              run_q, run_d;

    logic [3:0]        sh_nib_q  [DIGITS];
    logic              sh_dp_q   [DIGITS];
    logic [3:0]        act_nib_q [DIGITS];
    logic              act_dp_q  [DIGITS];

    logic [6:0]        segment_q, segment_d;
    logic              dp_q, dp_d;
    logic [DIGITS-1:0] digit_en_q, digit_en_d;
    logic              frame_tick_q;
    logic              wr_ready_q;
    logic              commit_nxt;
    logic              show_d;
    logic [3:0]        nib_d;
    logic              nib_dp_d;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    // Next scan position. run_q holds the position at digit 0 / count 0 for the
    // first edge after reset so that digit 0 gets its full dwell.
    always_comb begin
        run_d   = 1'b1;
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (run_q) begin
            unique case (state_q)
                S_SCAN: begin
                    if (cnt_q == CBITS'(DWELL - 1)) begin
                        cnt_d = '0;
`ifdef SEG7_BLANK_EN
                        state_d = S_BLANK;
`else
                        idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
`endif
                    end else begin
                        cnt_d = cnt_q + CBITS'(1);
                    end
                end
`ifdef SEG7_BLANK_EN
                S_BLANK: begin
                    if (cnt_q == CBITS'(BLANK_CYC - 1)) begin
                        cnt_d   = '0;
                        state_d = S_SCAN;
                        idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
                    end else begin
                        cnt_d = cnt_q + CBITS'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Outputs are registered from the next position so they line up with the
    // position registers. frame_tick_q marks the current cycle as the commit
    // cycle, so on that edge the shadow bank is what becomes visible.
    always_comb begin
`ifdef SEG7_BLANK_EN
        commit_nxt = (state_d == S_BLANK) && (cnt_d == CBITS'(BLANK_CYC - 1))
                     && (idx_d == IW'(DIGITS - 1));
        show_d     = (state_d == S_SCAN);
`else
        commit_nxt = (cnt_d == CBITS'(DWELL - 1)) && (idx_d == IW'(DIGITS - 1));
        show_d     = 1'b1;
`endif
        nib_d      = frame_tick_q ? sh_nib_q[idx_d] : act_nib_q[idx_d];
        nib_dp_d   = frame_tick_q ? sh_dp_q[idx_d]  : act_dp_q[idx_d];
        digit_en_d = show_d ? (DIGITS'(1) << idx_d) : '0;
        segment_d  = show_d ? hex7(nib_d) : 7'h00;
        dp_d       = show_d & nib_dp_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_SCAN;
            idx_q        <= '0;
            cnt_q        <= '0;
            run_q        <= 1'b0;
            segment_q    <= '0;
            dp_q         <= 1'b0;
            digit_en_q   <= '0;
            frame_tick_q <= 1'b0;
            wr_ready_q   <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                sh_nib_q[i]  <= '0;
                sh_dp_q[i]   <= 1'b0;
                act_nib_q[i] <= '0;
                act_dp_q[i]  <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            run_q        <= run_d;
            segment_q    <= segment_d;
            dp_q         <= dp_d;
            digit_en_q   <= digit_en_d;
            frame_tick_q <= commit_nxt;
            wr_ready_q   <= ~commit_nxt;
            if (frame_tick_q) begin
                for (int i = 0; i < DIGITS; i++) begin
                    act_nib_q[i] <= sh_nib_q[i];
                    act_dp_q[i]  <= sh_dp_q[i];
                end
            end
            if (wr_valid && wr_ready_q && (32'(wr_idx) < DIGITS)) begin
                sh_nib_q[wr_idx] <= wr_data;
                sh_dp_q[wr_idx]  <= wr_dp;
            end
        end
    end

    assign segment    = segment_q;
    assign dp         = dp_q;
    assign digit_en   = digit_en_q;
    assign frame_tick = frame_tick_q;
    assign wr_ready   = wr_ready_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

    localparam int D  = 4;
    localparam int DW = 4;
`ifdef SEG7_BLANK_EN
    localparam int B  = 2;
`else
    localparam int B  = 0;
`endif
    localparam int SLOT = DW + B;
    localparam int FP   = D * SLOT;
    localparam int P5   = 5 * (2 + B);

    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [1:0] wr_idx = '0;
    logic [3:0] wr_data = '0;
    logic       wr_dp = 1'b0;
    logic [6:0] segment;
    logic       dp;
    logic [3:0] digit_en;
    logic       frame_tick;

    logic       w5_valid = 1'b0;
    logic       w5_ready;
    logic [2:0] w5_idx = '0;
    logic [3:0] w5_data = '0;
    logic       w5_dp = 1'b0;
    logic [6:0] seg5;
    logic       dp5;
    logic [4:0] den5;
    logic       tick5;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.DIGITS(D), .DWELL(DW), .CBITS(4), .BLANK_CYC(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_idx(wr_idx), .wr_data(wr_data), .wr_dp(wr_dp), .segment(segment),
        .dp(dp), .digit_en(digit_en), .frame_tick(frame_tick));

    seg7_scan_ctrl #(.DIGITS(5), .DWELL(2), .CBITS(4), .BLANK_CYC(2)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .wr_valid(w5_valid), .wr_ready(w5_ready),
        .wr_idx(w5_idx), .wr_data(w5_data), .wr_dp(w5_dp), .segment(seg5),
        .dp(dp5), .digit_en(den5), .frame_tick(tick5));

    // Reference model: time since reset release, shadow/active banks of {dp, nibble}.
    int         m_t;
    logic [4:0] m_sh  [D];
    logic [4:0] m_act [D];

    task automatic model_reset();
        m_t = 0;
        for (int i = 0; i < D; i++) begin
            m_sh[i]  = '0;
            m_act[i] = '0;
        end
    endtask

    function automatic logic [13:0] model_exp();
        int pos, dig, w;
        logic on, commit;
        logic [3:0] den;
        pos    = m_t % FP;
        dig    = pos / SLOT;
        w      = pos % SLOT;
        on     = (w < DW);
        commit = (pos == FP - 1);
        den    = on ? 4'(1 << dig) : 4'h0;
        return {den, on ? HEX[m_act[dig][3:0]] : 7'h00, on & m_act[dig][4], commit, ~commit};
    endfunction

    function automatic logic [13:0] dut_pack();
        return {digit_en, segment, dp, frame_tick, wr_ready};
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d: got %h expected %h", name, m_t, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, mirror it in the model.
    task automatic step(input logic v, input logic [1:0] idx, input logic [3:0] d, input logic p);
        logic commit;
        wr_valid = v; wr_idx = idx; wr_data = d; wr_dp = p;
        @(posedge clk);
        commit = ((m_t % FP) == FP - 1);
        if (commit)
            for (int i = 0; i < D; i++) m_act[i] = m_sh[i];
        if (v && !commit) m_sh[idx] = {p, d};
        m_t++;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    typedef struct {
        int         n;
        logic       v;
        logic [1:0] idx;
        logic [3:0] d;
        logic       p;
        logic [3:0] den;
        logic [6:0] seg;
        logic       edp;
        logic       tick;
        logic       rdy;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(int n, logic v, logic [1:0] idx, logic [3:0] d, logic p,
                                logic [3:0] den, logic [6:0] seg, logic edp, logic tick);
        vec_t r;
        r.n = n; r.v = v; r.idx = idx; r.d = d; r.p = p;
        r.den = den; r.seg = seg; r.edp = edp; r.tick = tick; r.rdy = ~tick;
        return r;
    endfunction

    initial begin
        bit found;
        bit ok5;

        tbl[0]  = mk(2, 0, 0, 0,    0, 4'b0001, 7'h3F, 0, 0);
        tbl[1]  = mk(1, 1, 2, 4'h8, 1, 4'b0001, 7'h3F, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0,    0, 4'b0001, 7'h3F, 0, 0);
        tbl[3]  = mk(4, 0, 0, 0,    0, 4'b0010, 7'h3F, 0, 0);
        tbl[4]  = mk(4, 0, 0, 0,    0, 4'b0100, 7'h3F, 0, 0);
        tbl[5]  = mk(3, 0, 0, 0,    0, 4'b1000, 7'h3F, 0, 0);
        tbl[6]  = mk(1, 1, 3, 4'hF, 0, 4'b1000, 7'h3F, 0, 1);
        tbl[7]  = mk(1, 1, 3, 4'hF, 0, 4'b0001, 7'h3F, 0, 0);
        tbl[8]  = mk(3, 0, 0, 0,    0, 4'b0001, 7'h3F, 0, 0);
        tbl[9]  = mk(4, 0, 0, 0,    0, 4'b0010, 7'h3F, 0, 0);
        tbl[10] = mk(4, 0, 0, 0,    0, 4'b0100, 7'h7F, 1, 0);
        tbl[11] = mk(3, 0, 0, 0,    0, 4'b1000, 7'h3F, 0, 0);
        tbl[12] = mk(1, 0, 0, 0,    0, 4'b1000, 7'h3F, 0, 1);
        tbl[13] = mk(4, 0, 0, 0,    0, 4'b0001, 7'h3F, 0, 0);
        tbl[14] = mk(4, 0, 0, 0,    0, 4'b0010, 7'h3F, 0, 0);
        tbl[15] = mk(4, 0, 0, 0,    0, 4'b0100, 7'h7F, 1, 0);
        tbl[16] = mk(3, 0, 0, 0,    0, 4'b1000, 7'h71, 0, 0);
        tbl[17] = mk(1, 0, 0, 0,    0, 4'b1000, 7'h71, 0, 1);

        model_reset();
        repeat (2) @(negedge clk);
        check("reset_state", dut_pack(), 14'h0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);

`ifndef SEG7_BLANK_EN
        foreach (tbl[r]) begin
            for (int k = 0; k < tbl[r].n; k++) begin
                check("table", dut_pack(),
                      {tbl[r].den, tbl[r].seg, tbl[r].edp, tbl[r].tick, tbl[r].rdy});
                step(tbl[r].v, tbl[r].idx, tbl[r].d, tbl[r].p);
            end
        end
`endif

        for (int k = 0; k < 300; k++) begin
            check("random", dut_pack(), model_exp());
            step($urandom_range(0, 9) < 3, 2'($urandom), 4'($urandom), 1'($urandom));
        end

        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            if ((m_t % FP) == 3 * SLOT + 1) found = 1;
            else begin
                check("seek", dut_pack(), model_exp());
                step(0, 0, 0, 0);
            end
        end
        check("seek_digit3", 14'(found), 14'h1);
        #2 rst_n = 1'b0;
        #1 check("async_reset", dut_pack(), 14'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("post_reset", dut_pack(), {4'b0001, 7'h3F, 1'b0, 1'b0, 1'b1});
        for (int k = 0; k < 60; k++) begin
            check("after_reset", dut_pack(), model_exp());
            step($urandom_range(0, 9) < 4, 2'($urandom), 4'($urandom), 1'($urandom));
        end

        for (int j = 5; j < 8; j++) begin
            w5_valid = 1'b1; w5_idx = 3'(j); w5_data = 4'h8; w5_dp = 1'b1;
            ok5 = 0;
            for (int k = 0; k < 20 && !ok5; k++) begin
                if (w5_ready) ok5 = 1;
                else @(negedge clk);
            end
            check("oor_ready", 14'(ok5), 14'h1);
            @(posedge clk);
            @(negedge clk);
            w5_valid = 1'b0;
        end
        for (int k = 0; k < 2 * P5 + 2; k++) begin
            check("oor_display", {5'h0, seg5, dp5, 1'b0},
                  (den5 != 5'h0) ? {5'h0, 7'h3F, 1'b0, 1'b0} : 14'h0);
            check("oor_onehot", 14'($countones(den5) <= 1), 14'h1);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
